// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   - state_e        : frame FSM states, in frame order
//   - rx_state_e     : 8N1 receiver states
//   - frame_field_e  : order of the fields on the wire
//   - SYNC_BYTE_DEFAULT, MAX_LEN, len_valid()
package uart_prog_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLen,
        StData,
        StChk,
        StRstPulse
    } state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    // Wire order: SYNC, START (addr in [3:0]), LEN, LEN x DATA, CHK.
    typedef enum logic [2:0] {
        FldSync,
        FldStart,
        FldLen,
        FldData,
        FldChk
    } frame_field_e;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h5A;
    localparam int unsigned MAX_LEN           = 16;

    function automatic logic len_valid(input logic [7:0] len);
        return (len != 8'd0) && (len <= 8'(MAX_LEN));
    endfunction

endpackage

// File: rtl/uart_prog_loader_uart_rx.sv
// uart_rx_8n1: 8N1 UART receiver.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_rx          raw rx line (asynchronous, idle high)
//   o_byte_valid  1-cycle strobe, byte received with a good stop bit
//   o_byte        received byte, valid with o_byte_valid
//   o_frame_err   1-cycle strobe, stop bit sampled low
//   o_active      receiver is inside a character (start..stop)
module uart_rx_8n1
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err,
    output logic       o_active
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_sync;
    logic             r_rx_prev;
    rx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;

    rx_state_e        w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [2:0]       w_bit_idx_d;
    logic [7:0]       w_shift_d;
    logic             w_byte_valid_d;
    logic             w_frame_err_d;
    logic             w_rx;
    logic             w_fall;

    assign w_rx   = r_sync[1];
    // Edge rather than level: a line held low after a framing error must not restart.
    assign w_fall = r_rx_prev & ~w_rx;

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt + 1'b1;
        w_bit_idx_d    = r_bit_idx;
        w_shift_d      = r_shift;
        w_byte_valid_d = 1'b0;
        w_frame_err_d  = 1'b0;
        case (r_state)
            RxIdle: begin
                w_cnt_d = '0;
                if (w_fall) begin
                    w_state_d = RxStart;
                end
            end
            RxStart: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_d     = '0;
                    w_bit_idx_d = '0;
                    // Line back high at mid start bit: glitch, not a character.
                    w_state_d   = w_rx ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_d     = '0;
                    w_shift_d   = {w_rx, r_shift[7:1]};
                    w_bit_idx_d = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_d        = '0;
                    w_state_d      = RxIdle;
                    w_byte_valid_d = w_rx;
                    w_frame_err_d  = ~w_rx;
                end
            end
            default: w_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= 2'b11;
            r_rx_prev    <= 1'b1;
            r_state      <= RxIdle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_rx};
            r_rx_prev    <= w_rx;
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_bit_idx    <= w_bit_idx_d;
            r_shift      <= w_shift_d;
            r_byte_valid <= w_byte_valid_d;
            r_frame_err  <= w_frame_err_d;
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_shift;
    assign o_frame_err  = r_frame_err;
    assign o_active     = (r_state != RxIdle);

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives framed program bytes over UART and drives the CPU
// program-load interface, then pulses the CPU reset after a good frame.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   rx_i        UART rx line, idle high
//   load_en     CPU load-mode select
//   load_addr   memory write address
//   load_data   memory write data
//   cpu_rst_n   CPU reset, active low
//   busy        frame in progress (valid header seen, not yet ended/aborted)
//   done        1-cycle pulse, frame loaded with good checksum
//   err         1-cycle pulse, checksum/stop-bit/length/timeout error
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_BITS = 32,
    parameter int unsigned RST_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       load_en,
    output logic [3:0] load_addr,
    output logic [7:0] load_data,
    output logic       cpu_rst_n,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);
    localparam int unsigned RST_W     = $clog2(RST_CYCLES + 1);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_frame_err;
    logic       w_rx_active;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (rx_i),
        .o_byte_valid(w_byte_valid),
        .o_byte      (w_byte),
        .o_frame_err (w_frame_err),
        .o_active    (w_rx_active)
    );

    state_e           r_state,     w_state_d;
    logic             r_load_en,   w_load_en_d;
    logic [3:0]       r_load_addr, w_load_addr_d;
    logic [7:0]       r_load_data, w_load_data_d;
    logic [3:0]       r_next_addr, w_next_addr_d;
    logic [4:0]       r_remaining, w_remaining_d;
    logic [7:0]       r_chk,       w_chk_d;
    logic             r_cpu_rst_n, w_cpu_rst_n_d;
    logic             r_busy,      w_busy_d;
    logic             r_done,      w_done_d;
    logic             r_err,       w_err_d;
    logic [TO_W-1:0]  r_to_cnt,    w_to_cnt_d;
    logic [RST_W-1:0] r_rst_cnt,   w_rst_cnt_d;
    logic             w_timeout;

    // Only idle line time counts towards the timeout; a character in flight
    // always takes ~10 bit-times, longer than small TIMEOUT_BITS settings.
    assign w_timeout = r_busy && !w_byte_valid && (r_to_cnt == TO_W'(TO_CYCLES));

    always_comb begin
        w_state_d     = r_state;
        w_load_en_d   = r_load_en;
        w_load_addr_d = r_load_addr;
        w_load_data_d = r_load_data;
        w_next_addr_d = r_next_addr;
        w_remaining_d = r_remaining;
        w_chk_d       = r_chk;
        w_cpu_rst_n_d = r_cpu_rst_n;
        w_busy_d      = r_busy;
        w_done_d      = 1'b0;
        w_err_d       = 1'b0;
        w_rst_cnt_d   = r_rst_cnt;
        w_to_cnt_d    = (r_busy && !w_byte_valid && !w_rx_active) ? r_to_cnt + 1'b1 : '0;

        if (r_busy && (w_frame_err || w_timeout)) begin
            w_err_d     = 1'b1;
            w_busy_d    = 1'b0;
            w_load_en_d = 1'b0;
            w_to_cnt_d  = '0;
            w_state_d   = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_byte_valid && (w_byte == SYNC_BYTE)) begin
                        w_busy_d  = 1'b1;
                        w_state_d = StAddr;
                    end
                end
                StAddr: begin
                    if (w_byte_valid) begin
                        w_next_addr_d = w_byte[3:0];
                        w_chk_d       = w_byte;
                        w_state_d     = StLen;
                    end
                end
                StLen: begin
                    if (w_byte_valid) begin
                        if (len_valid(w_byte)) begin
                            w_remaining_d = w_byte[4:0];
                            w_chk_d       = r_chk ^ w_byte;
                            w_state_d     = StData;
                        end else begin
                            w_err_d   = 1'b1;
                            w_busy_d  = 1'b0;
                            w_state_d = StIdle;
                        end
                    end
                end
                StData: begin
                    if (w_byte_valid) begin
                        w_load_en_d   = 1'b1;
                        w_load_addr_d = r_next_addr;
                        w_load_data_d = w_byte;
                        w_next_addr_d = r_next_addr + 4'd1;
                        w_chk_d       = r_chk ^ w_byte;
                        w_remaining_d = r_remaining - 5'd1;
                        if (r_remaining == 5'd1) begin
                            w_state_d = StChk;
                        end
                    end
                end
                StChk: begin
                    if (w_byte_valid) begin
                        w_load_en_d = 1'b0;
                        w_busy_d    = 1'b0;
                        if (w_byte == r_chk) begin
                            w_done_d      = 1'b1;
                            w_cpu_rst_n_d = 1'b0;
                            w_rst_cnt_d   = '0;
                            w_state_d     = StRstPulse;
                        end else begin
                            // Bytes already written stay in CPU memory.
                            w_err_d   = 1'b1;
                            w_state_d = StIdle;
                        end
                    end
                end
                StRstPulse: begin
                    w_rst_cnt_d = r_rst_cnt + 1'b1;
                    if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                        w_cpu_rst_n_d = 1'b1;
                        w_state_d     = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_load_en   <= 1'b0;
            r_load_addr <= '0;
            r_load_data <= '0;
            r_next_addr <= '0;
            r_remaining <= '0;
            r_chk       <= '0;
            r_cpu_rst_n <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
            r_rst_cnt   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_load_en   <= w_load_en_d;
            r_load_addr <= w_load_addr_d;
            r_load_data <= w_load_data_d;
            r_next_addr <= w_next_addr_d;
            r_remaining <= w_remaining_d;
            r_chk       <= w_chk_d;
            r_cpu_rst_n <= w_cpu_rst_n_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_err       <= w_err_d;
            r_to_cnt    <= w_to_cnt_d;
            r_rst_cnt   <= w_rst_cnt_d;
        end
    end

    assign load_en   = r_load_en;
    assign load_addr = r_load_addr;
    assign load_data = r_load_data;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
